// File: rtl/rng_pkg.sv
// Shared types and defaults for the LFSR random number bank.
// FSM states, default taps/seeds and the draw mask helper.
package rng_pkg;

    typedef enum logic {
        IDLE,
        DRAW
    } state_t;

    localparam logic [8:0]  DEF_TAPS  = 9'b1_0001_0010;
    localparam logic [35:0] DEF_SEEDS = {9'h0B9, 9'h016, 9'h041, 9'h096};

    // Smallest all-ones mask covering lim-1; lim=0 gives all ones, lim=1 gives 0.
    function automatic logic [31:0] mask_from_limit(input logic [31:0] lim);
        logic [31:0] m;
        m = lim - 32'd1;
        for (int i = 1; i < 32; i = i * 2) begin
            m = m | (m >> i);
        end
        return m;
    endfunction

endpackage

// File: rtl/lfsr_rng_bank_if.sv
// Draw port and random word bundle of the LFSR bank.
// master drives requests, slave is the bank itself.
interface lfsr_rng_bank_if #(
    parameter int CHANNELS = 4
);
    logic                init;
    logic                req;
    logic [CHANNELS-1:0] limit;
    logic [CHANNELS-1:0] rn;
    logic                busy;
    logic                valid;
    logic [CHANNELS-1:0] value;

    modport master (
        output init, req, limit,
        input  rn, busy, valid, value
    );

    modport slave (
        input  init, req, limit,
        output rn, busy, valid, value
    );
endinterface

// File: rtl/lfsr_channel.sv
// One Fibonacci LFSR with seed reload.
// RNG_LOCKUP_RECOVER_EN: an all-zero state reloads 1 on the next edge.
module lfsr_channel #(
    parameter int                LFSR_W = 9,
    parameter logic [LFSR_W-1:0] TAPS   = 9'b1_0001_0010,
    parameter logic [LFSR_W-1:0] SEED   = 9'h096
) (
    input  logic clock,
    input  logic reset,
    input  logic init,
    output logic msb
);
    logic [LFSR_W-1:0] s;

    // Seed on reset/init, otherwise shift in the XOR of the tapped bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s <= SEED;
        end else if (init) begin
            s <= SEED;
`ifdef RNG_LOCKUP_RECOVER_EN
        end else if (s == '0) begin
            s <= {{(LFSR_W-1){1'b0}}, 1'b1};
`endif
        end else begin
            s <= {s[LFSR_W-2:0], ^(s & TAPS)};
        end
    end

    assign msb = s[LFSR_W-1];
endmodule

// File: rtl/lfsr_rng_bank.sv
// Bank of LFSRs forming a random word, plus a bounded draw port.
// Build option RNG_LOCKUP_RECOVER_EN enables zero-state recovery.
module lfsr_rng_bank
    import rng_pkg::*;
#(
    parameter int                         CHANNELS  = 4,
    parameter int                         LFSR_W    = 9,
    parameter logic [LFSR_W-1:0]          TAPS      = DEF_TAPS,
    parameter logic [CHANNELS*LFSR_W-1:0] SEEDS     = DEF_SEEDS,
    parameter int                         MAX_TRIES = 4
) (
    input logic             clock,
    input logic             reset,
    lfsr_rng_bank_if.slave  bus
);
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0] LAST = TW'(MAX_TRIES - 1);

    logic [CHANNELS-1:0] rn;
    logic [CHANNELS-1:0] mask;
    logic [CHANNELS-1:0] w;
    logic                hit;

    state_t              state_q, state_d;
    logic [TW-1:0]       tries_q, tries_d;
    logic [CHANNELS-1:0] limit_q, limit_d;
    logic [CHANNELS-1:0] value_q, value_d;
    logic                valid_q, valid_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        lfsr_channel #(
            .LFSR_W (LFSR_W),
            .TAPS   (TAPS),
            .SEED   (SEEDS[i*LFSR_W +: LFSR_W])
        ) u_ch (
            .clock (clock),
            .reset (reset),
            .init  (bus.init),
            .msb   (rn[i])
        );
    end

    // Draw FSM: accept, sample, reject/retry and fallback decisions.
    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        limit_d = limit_q;
        value_d = value_q;
        valid_d = 1'b0;
        mask    = CHANNELS'(mask_from_limit({{(32-CHANNELS){1'b0}}, limit_q}));
        w       = rn & mask;
        hit     = (limit_q == '0) || (w < limit_q);
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    state_d = DRAW;
                    limit_d = bus.limit;
                    tries_d = '0;
                end
            end
            DRAW: begin
                if (bus.init) begin
                    state_d = IDLE;
                end else if (hit) begin
                    value_d = w;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else if (tries_q == LAST) begin
                    value_d = w - limit_q;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    tries_d = tries_q + 1'b1;
                end
            end
        endcase
    end

    // FSM and result registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tries_q <= '0;
            limit_q <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            limit_q <= limit_d;
            value_q <= value_d;
            valid_q <= valid_d;
        end
    end

    assign bus.rn    = rn;
    assign bus.busy  = (state_q == DRAW);
    assign bus.valid = valid_q;
    assign bus.value = value_q;
endmodule

// File: tb/tb_lfsr_rng_bank.sv
// Self-checking bench for lfsr_rng_bank against a behavioural model.
// Honours RNG_LOCKUP_RECOVER_EN for the zero-seed channel checks.
module tb_lfsr_rng_bank;
    localparam int MAXT = 4;

    logic clock = 1'b0;
    logic rst   = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    logic [3:0] last_val = 4'h0;

    always #5 clock = ~clock;

    lfsr_rng_bank_if #(.CHANNELS(4)) ifm ();
    lfsr_rng_bank_if #(.CHANNELS(4)) ifs ();
    lfsr_rng_bank_if #(.CHANNELS(4)) ifz ();

    lfsr_rng_bank dut (
        .clock (clock),
        .reset (rst),
        .bus   (ifm)
    );

    lfsr_rng_bank #(.SEEDS({4{9'h1FF}})) dut_s (
        .clock (clock),
        .reset (rst),
        .bus   (ifs)
    );

    lfsr_rng_bank #(.SEEDS({9'h0B9, 9'h016, 9'h041, 9'h000})) dut_z (
        .clock (clock),
        .reset (rst),
        .bus   (ifz)
    );

    int seed_m[4] = '{'h096, 'h041, 'h016, 'h0B9};
    int seed_z[4] = '{'h000, 'h041, 'h016, 'h0B9};
    int ms[4];
    int mz[4];

    function automatic int step(input int s);
        int p;
        p = $countones(s & 'h112) % 2;
        return ((s * 2) + p) % 512;
    endfunction

    function automatic int stepz(input int s);
`ifdef RNG_LOCKUP_RECOVER_EN
        if (s == 0) return 1;
`endif
        return step(s);
    endfunction

    function automatic logic [3:0] m_rn();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (ms[i] >= 256);
        return r;
    endfunction

    function automatic logic [3:0] z_rn();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (mz[i] >= 256);
        return r;
    endfunction

    function automatic int bmask(input int lim);
        int k;
        if (lim == 0) return 15;
        k = 0;
        while ((1 << k) < lim) k++;
        return (1 << k) - 1;
    endfunction

    always @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                ms[i] <= seed_m[i];
                mz[i] <= seed_z[i];
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                ms[i] <= ifm.init ? seed_m[i] : step(ms[i]);
                mz[i] <= stepz(mz[i]);
            end
        end
    end

    task automatic do_draw(input int lim, input bit with_init, input bit chk_pulse,
                           output logic [3:0] got);
        int w, t, edges;
        bit done, midbad;
        logic [3:0] exp;
        exp = 4'h0;
        ifm.req = 1'b1;
        ifm.limit = 4'(lim);
        ifm.init = with_init;
        @(posedge clock); #1;
        ifm.req = 1'b0;
        ifm.init = 1'b0;
        edges = 1;
        t = 0;
        done = 1'b0;
        midbad = 1'b0;
        while (!done) begin
            if (ifm.busy !== 1'b1 || ifm.valid !== 1'b0) midbad = 1'b1;
            w = int'(m_rn()) & bmask(lim);
            if (lim == 0 || w < lim) begin
                exp = 4'(w);
                done = 1'b1;
            end else begin
                t++;
                if (t == MAXT) begin
                    exp = 4'(w - lim);
                    done = 1'b1;
                end
            end
            @(posedge clock); #1;
            edges++;
        end
        compared++;
        if (midbad || ifm.valid !== 1'b1 || ifm.busy !== 1'b0 || ifm.value !== exp) begin
            mismatched++;
            $display("FAIL draw lim=%0d edges=%0d: valid=%b busy=%b value=%h midbad=%b, required valid=1 busy=0 value=%h",
                     lim, edges, ifm.valid, ifm.busy, ifm.value, midbad, exp);
        end
        got = ifm.value;
        last_val = exp;
        if (chk_pulse) begin
            @(posedge clock); #1;
            compared++;
            if (ifm.valid !== 1'b0 || ifm.value !== exp) begin
                mismatched++;
                $display("FAIL pulse lim=%0d: valid=%b value=%h, required valid=0 value=%h",
                         lim, ifm.valid, ifm.value, exp);
            end
        end
    endtask

    task automatic test_reset();
        ifm.init = 0; ifm.req = 0; ifm.limit = 0;
        ifs.init = 0; ifs.req = 0; ifs.limit = 0;
        ifz.init = 0; ifz.req = 0; ifz.limit = 0;
        rst = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        compared++;
        if (ifm.rn !== 4'h0 || ifm.busy !== 1'b0 || ifm.valid !== 1'b0 || ifm.value !== 4'h0) begin
            mismatched++;
            $display("FAIL reset_state: rn=%h busy=%b valid=%b value=%h, required 0 0 0 0",
                     ifm.rn, ifm.busy, ifm.valid, ifm.value);
        end
        rst = 1'b1;
    endtask

    task automatic test_lockup();
        for (int c = 0; c < 100; c++) begin
            @(posedge clock); #1;
            compared++;
            if (ifz.rn !== z_rn()) begin
                mismatched++;
                $display("FAIL lockup cycle %0d: rn=%h, required %h", c, ifz.rn, z_rn());
            end
        end
    endtask

    task automatic test_first_edges();
        @(posedge clock); #1;
        compared++;
        if (ifm.rn !== 4'h9) begin
            mismatched++;
            $display("FAIL rn_first_edge: got %h, required 9", ifm.rn);
        end
        ifm.init = 1'b1;
        @(posedge clock); #1;
        ifm.init = 1'b0;
        compared++;
        if (ifm.rn !== 4'h0) begin
            mismatched++;
            $display("FAIL rn_after_init: got %h, required 0", ifm.rn);
        end
    endtask

    task automatic test_full_range();
        logic [3:0] g;
        for (int n = 0; n < 20; n++) do_draw(0, 1'b0, 1'b1, g);
    endtask

    task automatic test_limit_one();
        logic [3:0] g;
        for (int n = 0; n < 1000; n++) begin
            do_draw(1, 1'b0, 1'b0, g);
            compared++;
            if (g !== 4'h0) begin
                mismatched++;
                $display("FAIL limit_one value: got %h, required 0", g);
            end
        end
    endtask

    task automatic test_limit_five();
        logic [3:0] g;
        for (int n = 0; n < 100; n++) begin
            do_draw(5, 1'b0, ($urandom_range(0, 1) == 1), g);
            compared++;
            if (g >= 4'd5) begin
                mismatched++;
                $display("FAIL limit_five bound: got %h, required < 5", g);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] g;
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
            do_draw($urandom_range(0, 15), ($urandom_range(0, 7) == 0), 1'b0, g);
        end
    endtask

    task automatic test_stuck();
        int n;
        ifs.req = 1'b1;
        ifs.limit = 4'd9;
        @(posedge clock); #1;
        ifs.req = 1'b0;
        n = 1;
        while (ifs.valid !== 1'b1 && n < 12) begin
            @(posedge clock); #1;
            n++;
        end
        compared++;
        if (n != 5 || ifs.value !== 4'd6 || ifs.rn !== 4'hF) begin
            mismatched++;
            $display("FAIL stuck_fallback: edges=%0d value=%h rn=%h, required edges=5 value=6 rn=f",
                     n, ifs.value, ifs.rn);
        end
    endtask

    task automatic test_abort();
        ifm.req = 1'b1;
        ifm.limit = 4'd0;
        @(posedge clock); #1;
        compared++;
        if (ifm.busy !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_busy: got %b, required 1", ifm.busy);
        end
        ifm.init = 1'b1;
        @(posedge clock); #1;
        ifm.init = 1'b0;
        ifm.req = 1'b0;
        compared++;
        if (ifm.busy !== 1'b0 || ifm.valid !== 1'b0 || ifm.value !== last_val) begin
            mismatched++;
            $display("FAIL abort: busy=%b valid=%b value=%h, required 0 0 %h",
                     ifm.busy, ifm.valid, ifm.value, last_val);
        end
        @(posedge clock); #1;
        compared++;
        if (ifm.busy !== 1'b0 || ifm.valid !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_not_queued: busy=%b valid=%b, required 0 0",
                     ifm.busy, ifm.valid);
        end
    endtask

    task automatic test_async_reset();
        ifm.req = 1'b1;
        ifm.limit = 4'd9;
        @(posedge clock); #1;
        ifm.req = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        compared++;
        if (ifm.busy !== 1'b0 || ifm.valid !== 1'b0 || ifm.value !== 4'h0 || ifm.rn !== 4'h0) begin
            mismatched++;
            $display("FAIL async_reset: busy=%b valid=%b value=%h rn=%h, required 0 0 0 0",
                     ifm.busy, ifm.valid, ifm.value, ifm.rn);
        end
        last_val = 4'h0;
        @(posedge clock); #1;
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        fork
            test_lockup();
            begin
                test_first_edges();
                test_full_range();
            end
        join
        test_limit_one();
        test_limit_five();
        test_random();
        test_stuck();
        test_abort();
        test_async_reset();
        test_full_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
